// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd_unit engine: state encoding and default width.
package gcd_pkg;

  localparam int GCD_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } gcd_state_t;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers plus compare/subtract/zero-detect for the iterative GCD.
// One load, swap or subtract is applied per clock, as selected by the FSM.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int W = GCD_W_DEFAULT
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         i_load,
  input  logic         i_swap,
  input  logic         i_sub,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_a,
  output logic         o_b_zero,
  output logic         o_a_lt_b
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] w_diff;

  // Only used when r_a >= r_b, so the W-bit difference never wraps.
  assign w_diff   = r_a - r_b;
  assign o_a_lt_b = (r_a < r_b);
  assign o_b_zero = (r_b == '0);
  assign o_a      = r_a;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_load) begin
      r_a <= i_a;
      r_b <= i_b;
    end else if (i_swap) begin
      r_a <= r_b;
      r_b <= r_a;
    end else if (i_sub) begin
      r_a <= w_diff;
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// Iterative subtract-or-swap GCD engine with valid/ready handshakes.
// Handshake outputs decode from the state register only.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int W = GCD_W_DEFAULT
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] A_IN,
  input  logic [W-1:0] B_IN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] RESULT
);

  gcd_state_t r_state;
  gcd_state_t w_state_next;
  logic       w_load;
  logic       w_swap;
  logic       w_sub;
  logic       w_b_zero;
  logic       w_a_lt_b;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_swap       = 1'b0;
    w_sub        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (IN_VALID) begin
          w_load       = 1'b1;
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_b_zero)      w_state_next = ST_DONE;
        else if (w_a_lt_b) w_swap = 1'b1;
        else               w_sub  = 1'b1;
      end
      ST_DONE: begin
        if (OUT_READY) w_state_next = ST_IDLE;
      end
      // The unused 2'b11 code recovers to IDLE on the next edge.
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign IN_READY  = (r_state == ST_IDLE);
  assign OUT_VALID = (r_state == ST_DONE);

  gcd_datapath #(.W(W)) u_datapath (
    .CLK      (CLK),
    .CLR      (CLR),
    .i_load   (w_load),
    .i_swap   (w_swap),
    .i_sub    (w_sub),
    .i_a      (A_IN),
    .i_b      (B_IN),
    .o_a      (RESULT),
    .o_b_zero (w_b_zero),
    .o_a_lt_b (w_a_lt_b)
  );

endmodule

// File: tb/tb_gcd_unit.sv
// Directed and small randomized checks of gcd_unit (W=8) against hand-computed values.
module tb_gcd_unit;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         CLR = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] A_IN = '0;
  logic [W-1:0] B_IN = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b1;
  logic [W-1:0] RESULT;

  int checks   = 0;
  int failures = 0;

  gcd_unit #(.W(W)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A_IN      (A_IN),
    .B_IN      (B_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT)
  );

  always #5 CLK = ~CLK;

  function automatic int ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Starts one transaction from IDLE (called at posedge+1), returns edge count and result.
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int n, output logic [W-1:0] res);
    A_IN     = a;
    B_IN     = b;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    n = 0;
    while (!OUT_VALID && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    res = RESULT;
  endtask

  task automatic run_case(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int exp_n);
    int n;
    logic [W-1:0] res;
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_ready: got %b want 1", name, IN_READY);
    end
    OUT_READY = 1'b1;
    start_and_wait(a, b, n, res);
    checks++;
    if (OUT_VALID !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: no OUT_VALID after %0d edges", name, n);
    end
    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL %s latency: got %0d edges want %0d", name, n, exp_n);
    end
    checks++;
    if (res !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %0d want %0d", name, res, exp_res);
    end
    @(posedge CLK); #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL %s return_idle: in_ready=%b out_valid=%b want 1/0", name, IN_READY, OUT_VALID);
    end
    $display("case %s gcd(%0d,%0d) -> %0d in %0d edges", name, a, b, res, n);
  endtask

  task automatic test_reset;
    int n;
    logic [W-1:0] res;
    int seen;
    #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || RESULT !== '0) begin
      failures++;
      $display("FAIL reset_initial: ready=%b valid=%b result=%0d want 1/0/0", IN_READY, OUT_VALID, RESULT);
    end
    @(posedge CLK); #1;
    CLR = 1'b0;
    @(posedge CLK); #1;
    // Start gcd(200,3), then abort asynchronously in the middle of CALC.
    A_IN = 8'd200; B_IN = 8'd3; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (10) begin @(posedge CLK); #1; end
    checks++;
    if (IN_READY !== 1'b0 || RESULT == 8'd200) begin
      failures++;
      $display("FAIL reset_precalc: ready=%b result=%0d want 0 and mid-computation", IN_READY, RESULT);
    end
    #2 CLR = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || RESULT !== '0) begin
      failures++;
      $display("FAIL reset_async: ready=%b valid=%b result=%0d want 1/0/0", IN_READY, OUT_VALID, RESULT);
    end
    @(posedge CLK); #1;
    CLR = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      if (OUT_VALID) seen++;
    end
    checks++;
    if (seen != 0 || IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_valid: out_valid cycles=%0d ready=%b want 0/1", seen, IN_READY);
    end
    $display("case reset abort of gcd(200,3) done");
    n = 0; res = '0;
  endtask

  task automatic test_backpressure;
    int n;
    logic [W-1:0] res;
    int bad;
    OUT_READY = 1'b0;
    start_and_wait(8'd48, 8'd18, n, res);
    checks++;
    if (OUT_VALID !== 1'b1 || res !== 8'd6) begin
      failures++;
      $display("FAIL bp_result: valid=%b result=%0d want 1/6", OUT_VALID, res);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      A_IN = 8'(i * 7 + 1); B_IN = 8'(i + 2); IN_VALID = i[0];
      @(posedge CLK); #1;
      if (RESULT !== 8'd6 || IN_READY !== 1'b0 || OUT_VALID !== 1'b1) bad++;
    end
    IN_VALID = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: ready=%b valid=%b want 1/0", IN_READY, OUT_VALID);
    end
    $display("case backpressure gcd(48,18) -> %0d held 20 cycles", res);
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int exp;
    int n;
    int both;
    int bad = 0;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp = ref_gcd(int'(a), int'(b));
      A_IN = a; B_IN = b; IN_VALID = 1'b1;
      OUT_READY = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      n = 0; both = 0;
      while (!(OUT_VALID && OUT_READY) && n < 600) begin
        if (IN_READY && OUT_VALID) both++;
        OUT_READY = 1'($urandom_range(0, 1));
        if (!(OUT_VALID && OUT_READY)) begin
          @(posedge CLK); #1;
          n++;
        end
      end
      checks++;
      if (OUT_VALID !== 1'b1 || RESULT !== 8'(exp) || both != 0) begin
        failures++;
        bad++;
        $display("FAIL rand gcd(%0d,%0d): valid=%b result=%0d want %0d overlap=%0d",
                 a, b, OUT_VALID, RESULT, exp, both);
      end
      $display("case rand gcd(%0d,%0d) -> %0d", a, b, RESULT);
      @(posedge CLK); #1;
      OUT_READY = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    run_case("basic_12_8",    8'd12,  8'd8,   8'd4,   6);
    run_case("zero_0_0",      8'd0,   8'd0,   8'd0,   1);
    run_case("zero_9_0",      8'd9,   8'd0,   8'd9,   1);
    run_case("zero_0_9",      8'd0,   8'd9,   8'd9,   2);
    run_case("worst_255_1",   8'd255, 8'd1,   8'd1,   257);
    run_case("equal_255_255", 8'd255, 8'd255, 8'd255, 3);
    run_case("back_to_back",  8'd21,  8'd14,  8'd7,   6);
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
